// File: rtl/dual_port_ram_param.sv
// Single-clock true dual-port byte-write SRAM with write-first same-port data and read-first cross-port data.
// Optional DPRAM_OUTREG_EN adds an output register stage (read latency 2).
module dual_port_ram_param #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 15,
  parameter int INIT_CLEAR = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_busy,
  input  logic                   a_en,
  input  logic [DATA_W/8-1:0]    a_we,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_din,
  output logic [DATA_W-1:0]      a_dout,
  output logic                   a_rvalid,
  input  logic                   b_en,
  input  logic [DATA_W/8-1:0]    b_we,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]      b_din,
  output logic [DATA_W-1:0]      b_dout,
  output logic                   b_rvalid,
  output logic                   collision
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ready;
  logic                a_wr, a_rd, b_wr, b_rd, same_addr;
  logic [DATA_W-1:0]   a_old, b_old, a_merged, b_merged;
  logic [BE_W-1:0]     a_byte_wr, b_byte_wr;
  logic [DATA_W-1:0]   a_dout_q, a_dout_d, b_dout_q, b_dout_d;
  logic                a_rvalid_q, b_rvalid_q, collision_q, collision_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Busy is also raised while reset is held so requesters never see a ready gap.
  assign init_busy = (state_q == ST_CLEAR) || (!rst_n && (INIT_CLEAR != 0));
  assign ready     = (state_q == ST_READY) && rst_n;

  assign a_wr      = ready && a_en && (|a_we);
  assign a_rd      = ready && a_en && !(|a_we);
  assign b_wr      = ready && b_en && (|b_we);
  assign b_rd      = ready && b_en && !(|b_we);
  assign same_addr = (a_addr == b_addr);
  assign a_old     = mem[a_addr];
  assign b_old     = mem[b_addr];

  // Port A owns overlapping bytes; B's write of those bytes is dropped.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_byte
    assign a_byte_wr[gi] = a_wr && a_we[gi];
    assign b_byte_wr[gi] = b_wr && b_we[gi] && !(same_addr && a_byte_wr[gi]);
    assign a_merged[gi*8 +: 8] = a_byte_wr[gi]              ? a_din[gi*8 +: 8] :
                                 (same_addr && b_byte_wr[gi]) ? b_din[gi*8 +: 8] :
                                                                a_old[gi*8 +: 8];
    assign b_merged[gi*8 +: 8] = b_byte_wr[gi]              ? b_din[gi*8 +: 8] :
                                 (same_addr && a_byte_wr[gi]) ? a_din[gi*8 +: 8] :
                                                                b_old[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst_n && (state_q == ST_CLEAR)) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      for (int i = 0; i < BE_W; i++) begin
        if (a_byte_wr[i]) mem[a_addr][i*8 +: 8] <= a_din[i*8 +: 8];
        if (b_byte_wr[i]) mem[b_addr][i*8 +: 8] <= b_din[i*8 +: 8];
      end
    end
  end

  assign a_dout_d    = a_rd ? a_old : (a_wr ? a_merged : a_dout_q);
  assign b_dout_d    = b_rd ? b_old : (b_wr ? b_merged : b_dout_q);
  assign collision_d = a_wr && b_wr && same_addr && (|(a_we & b_we));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_dout_q    <= '0;
      b_dout_q    <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      a_dout_q    <= a_dout_d;
      b_dout_q    <= b_dout_d;
      a_rvalid_q  <= a_rd;
      b_rvalid_q  <= b_rd;
      collision_q <= collision_d;
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [DATA_W-1:0] a_dout_o_q, b_dout_o_q;
  logic              a_rvalid_o_q, b_rvalid_o_q, collision_o_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_dout_o_q    <= '0;
      b_dout_o_q    <= '0;
      a_rvalid_o_q  <= 1'b0;
      b_rvalid_o_q  <= 1'b0;
      collision_o_q <= 1'b0;
    end else begin
      a_dout_o_q    <= a_dout_q;
      b_dout_o_q    <= b_dout_q;
      a_rvalid_o_q  <= a_rvalid_q;
      b_rvalid_o_q  <= b_rvalid_q;
      collision_o_q <= collision_q;
    end
  end

  assign a_dout    = a_dout_o_q;
  assign b_dout    = b_dout_o_q;
  assign a_rvalid  = a_rvalid_o_q;
  assign b_rvalid  = b_rvalid_o_q;
  assign collision = collision_o_q;
`else
  assign a_dout    = a_dout_q;
  assign b_dout    = b_dout_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign collision = collision_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed table-driven bench for dual_port_ram_param (DATA_W=64, ADDR_W=4, INIT_CLEAR=1).
module tb_dual_port_ram_param;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_busy;
  logic              a_en, b_en;
  logic [BE_W-1:0]   a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_din, b_din, a_dout, b_dout;
  logic              a_rvalid, b_rvalid, collision;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dual_port_ram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_CLEAR(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_rvalid(b_rvalid),
    .collision(collision)
  );

  typedef struct {
    logic              a_en;
    logic [BE_W-1:0]   a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_din;
    logic              b_en;
    logic [BE_W-1:0]   b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_din;
    logic [DATA_W-1:0] exp_a_dout;
    logic              exp_a_rvalid;
    logic [DATA_W-1:0] exp_b_dout;
    logic              exp_b_rvalid;
    logic              exp_collision;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
  endtask

  // Drive one cycle of requests, let the read pipeline drain, then compare.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    a_en = v.a_en; a_we = v.a_we; a_addr = v.a_addr; a_din = v.a_din;
    b_en = v.b_en; b_we = v.b_we; b_addr = v.b_addr; b_din = v.b_din;
    @(posedge clk);
    #1 idle();
`ifdef DPRAM_OUTREG_EN
    @(posedge clk);
`endif
    @(negedge clk);
    check({tag, ".a_dout"},    a_dout,            v.exp_a_dout);
    check({tag, ".a_rvalid"},  DATA_W'(a_rvalid), DATA_W'(v.exp_a_rvalid));
    check({tag, ".b_dout"},    b_dout,            v.exp_b_dout);
    check({tag, ".b_rvalid"},  DATA_W'(b_rvalid), DATA_W'(v.exp_b_rvalid));
    check({tag, ".collision"}, DATA_W'(collision), DATA_W'(v.exp_collision));
    $display("[TB] %s a_dout=%h a_rv=%0b b_dout=%h b_rv=%0b col=%0b",
             tag, a_dout, a_rvalid, b_dout, b_rvalid, collision);
  endtask

  // Called at a negedge where init_busy is expected high; counts busy cycles (bounded).
  task automatic measure_clear(output int n, output int rv_seen);
    n = 0;
    rv_seen = 0;
    while (init_busy && n < 100) begin
      n++;
      @(negedge clk);
      if (a_rvalid || b_rvalid) rv_seen++;
    end
  endtask

  function automatic vec_t mk(input logic ae, input logic [BE_W-1:0] awe, input logic [ADDR_W-1:0] aa,
                              input logic [DATA_W-1:0] ad, input logic be, input logic [BE_W-1:0] bwe,
                              input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                              input logic [DATA_W-1:0] ea, input logic erva,
                              input logic [DATA_W-1:0] eb, input logic ervb, input logic ecol);
    vec_t v;
    v.a_en = ae; v.a_we = awe; v.a_addr = aa; v.a_din = ad;
    v.b_en = be; v.b_we = bwe; v.b_addr = ba; v.b_din = bd;
    v.exp_a_dout = ea; v.exp_a_rvalid = erva;
    v.exp_b_dout = eb; v.exp_b_rvalid = ervb; v.exp_collision = ecol;
    return v;
  endfunction

  initial begin
    int   n_busy;
    int   rv_seen;
    vec_t v;

    // Outputs after each vector follow from the previous ones: idle ports hold their dout.
    vecs[0]  = mk(1, 8'hFF, 4'h3, 64'h1122334455667788, 0, 8'h00, 4'h0, 64'h0,
                  64'h1122334455667788, 0, 64'h0, 0, 0);
    vecs[1]  = mk(1, 8'h00, 4'h3, 64'h0, 0, 8'h00, 4'h0, 64'h0,
                  64'h1122334455667788, 1, 64'h0, 0, 0);
    vecs[2]  = mk(1, 8'h0F, 4'h3, 64'hAAAAAAAABBBBBBBB, 0, 8'h00, 4'h0, 64'h0,
                  64'h11223344BBBBBBBB, 0, 64'h0, 0, 0);
    vecs[3]  = mk(0, 8'h00, 4'h0, 64'h0, 1, 8'h00, 4'h3, 64'h0,
                  64'h11223344BBBBBBBB, 0, 64'h11223344BBBBBBBB, 1, 0);
    vecs[4]  = mk(1, 8'h03, 4'h5, 64'h1111111111111111, 1, 8'h06, 4'h5, 64'h2222222222222222,
                  64'h0000000000221111, 0, 64'h0000000000221111, 0, 1);
    vecs[5]  = mk(1, 8'h00, 4'h5, 64'h0, 1, 8'h00, 4'h5, 64'h0,
                  64'h0000000000221111, 1, 64'h0000000000221111, 1, 0);
    vecs[6]  = mk(1, 8'hFF, 4'h7, 64'hDEAD, 1, 8'h00, 4'h7, 64'h0,
                  64'hDEAD, 0, 64'h0, 1, 0);
    vecs[7]  = mk(0, 8'h00, 4'h0, 64'h0, 1, 8'h00, 4'h7, 64'h0,
                  64'hDEAD, 0, 64'hDEAD, 1, 0);
    vecs[8]  = mk(1, 8'h0F, 4'h9, 64'h1111111111111111, 1, 8'hF0, 4'h9, 64'h3333333333333333,
                  64'h3333333311111111, 0, 64'h3333333311111111, 0, 0);
    vecs[9]  = mk(1, 8'h00, 4'hA, 64'h0, 1, 8'h80, 4'hA, 64'hFFFFFFFFFFFFFFFF,
                  64'h0, 1, 64'hFF00000000000000, 0, 0);
    vecs[10] = mk(0, 8'hFF, 4'h3, 64'h0, 0, 8'h00, 4'h0, 64'h0,
                  64'h0, 0, 64'hFF00000000000000, 0, 0);
    vecs[11] = mk(1, 8'h00, 4'h3, 64'h0, 0, 8'h00, 4'h0, 64'h0,
                  64'h11223344BBBBBBBB, 1, 64'hFF00000000000000, 0, 0);
    vecs[12] = mk(1, 8'hFF, 4'hF, 64'hCAFE, 0, 8'h00, 4'h0, 64'h0,
                  64'hCAFE, 0, 64'hFF00000000000000, 0, 0);
    vecs[13] = mk(1, 8'h00, 4'h0, 64'h0, 1, 8'h00, 4'hF, 64'h0,
                  64'h0, 1, 64'hCAFE, 1, 0);

    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.a_dout",    a_dout,              64'h0);
    check("reset.b_dout",    b_dout,              64'h0);
    check("reset.rvalid",    DATA_W'({a_rvalid, b_rvalid}), 64'h0);
    check("reset.collision", DATA_W'(collision),  64'h0);
    check("reset.init_busy", DATA_W'(init_busy),  64'h1);

    rst_n = 1'b1;
    measure_clear(n_busy, rv_seen);
    check("clear.busy_cycles", DATA_W'(n_busy), 64'd16);
    $display("[TB] initial clear busy for %0d cycles", n_busy);

    for (int k = 0; k < 16; k++) begin
      v = mk(1, 8'h00, ADDR_W'(k), 64'h0, 1, 8'h00, ADDR_W'(15 - k), 64'h0, 64'h0, 1, 64'h0, 1, 0);
      run_vec(v, $sformatf("clear_read%0d", k));
    end

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a clear, with a read request held during the clear.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midclear.busy_at5", DATA_W'(init_busy), 64'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_en = 1'b1; a_addr = 4'h3;
    measure_clear(n_busy, rv_seen);
    idle();
    check("midclear.busy_cycles", DATA_W'(n_busy), 64'd16);
    check("midclear.no_rvalid",   DATA_W'(rv_seen), 64'd0);
    $display("[TB] restarted clear busy for %0d cycles, rvalid seen %0d", n_busy, rv_seen);

    run_vec(mk(1, 8'h00, 4'h3, 64'h0, 1, 8'h00, 4'h9, 64'h0, 64'h0, 1, 64'h0, 1, 0), "after_clear");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
